// File: rtl/dsp48a1_pkg.sv
// Shared constants and types for the DSP48A1 multiply-accumulate sequencer.
package dsp48a1_pkg;

  // Operand issue to P holding that slot's result (AREG/BREG, MREG, PREG)
  localparam int LAT = 3;

  localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
  localparam logic [7:0] OPM_ACC   = 8'b0000_1001;
  localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;

  localparam int PREADD_BIT = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/mac_tag_pipe.sv
// Shift register that follows each issued slot through the slice pipeline.
module mac_tag_pipe
  import dsp48a1_pkg::*;
#(
  parameter int DEPTH = LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  tag_t tag_in,
  output tag_t tag_head,
  output tag_t tag_tail
);

  tag_t [DEPTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else if (clr) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[DEPTH-2:0], tag_in};
    end
  end

  assign tag_head = pipe[0];
  assign tag_tail = pipe[DEPTH-1];

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Runs one DSP48A1 slice as a MAC engine over a valid/ready operand stream.
// Define MAC_PREADD_EN to add the in_d port and compute A*(D+B) per term.
module dsp48a1_mac_sequencer #(
  parameter int CNT_W = 16,
  parameter int LAT   = dsp48a1_pkg::LAT
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
`ifdef MAC_PREADD_EN
  input  logic [17:0]      in_d,
`endif
  output logic             res_valid,
  output logic [47:0]      res_data,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [17:0]      dsp_d,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p
);

  import dsp48a1_pkg::*;

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] acc_cnt;
  logic             rst_hold;
  logic             xfer;
  logic             abort_fire;
  tag_t             tag_push;
  tag_t             tag_mreg;
  tag_t             tag_p;

  assign busy       = (state != ST_IDLE);
  assign abort_fire = abort && busy;
  // Abort blocks the handshake so no operand slips in on the cancelling edge
  assign in_ready   = (state == ST_RUN) && (acc_cnt < len_q) && !abort;
  assign xfer       = in_valid && in_ready;
  assign res_valid  = (state == ST_DONE) && !abort;
  assign dsp_ce     = RSTN;
  assign dsp_rst    = rst_hold;

  assign dsp_a = xfer ? in_a : '0;
  assign dsp_b = xfer ? in_b : '0;
`ifdef MAC_PREADD_EN
  assign dsp_d = xfer ? in_d : '0;
`else
  assign dsp_d = '0;
`endif

  always_comb begin
    tag_push       = '0;
    tag_push.valid = xfer;
    tag_push.first = xfer && (acc_cnt == '0);
    tag_push.last  = xfer && (acc_cnt == len_q - CNT_W'(1));
  end

  // The slice registers OPMODE, so the head tag lines up with the product in MREG
  always_comb begin
    dsp_opmode = OPM_HOLD;
    casez (tag_mreg)
      3'b11?:  dsp_opmode = OPM_FIRST;
      3'b10?:  dsp_opmode = OPM_ACC;
      default: dsp_opmode = OPM_HOLD;
    endcase
`ifdef MAC_PREADD_EN
    if (busy || start) begin
      dsp_opmode[PREADD_BIT] = 1'b1;
    end
`endif
  end

  mac_tag_pipe #(
    .DEPTH (LAT)
  ) u_tag_pipe (
    .clk      (CLK),
    .rst_n    (RSTN),
    .clr      (abort_fire),
    .tag_in   (tag_push),
    .tag_head (tag_mreg),
    .tag_tail (tag_p)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      acc_cnt  <= '0;
      res_data <= '0;
      rst_hold <= 1'b1;
    end else begin
      rst_hold <= abort_fire;
      if (abort_fire) begin
        state   <= ST_IDLE;
        acc_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              len_q   <= len;
              acc_cnt <= '0;
              if (len == '0) begin
                res_data <= '0;
                state    <= ST_DONE;
              end else begin
                state <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (xfer) begin
              acc_cnt <= acc_cnt + CNT_W'(1);
              if (tag_push.last) begin
                state <= ST_DRAIN;
              end
            end
          end
          // The last slot's tag reaching the tail means P is final
          ST_DRAIN: begin
            if (tag_p ==? 3'b1?1) begin
              res_data <= dsp_p;
              state    <= ST_DONE;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Directed bench for dsp48a1_mac_sequencer with a behavioural DSP48A1 slice model.
// Define MAC_PREADD_EN to also exercise the pre-adder path.
module tb_dsp48a1_mac_sequencer;

  logic        CLK;
  logic        RSTN;
  logic        start;
  logic [15:0] len;
  logic        abort;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
`ifdef MAC_PREADD_EN
  logic [17:0] in_d;
`endif
  logic        res_valid;
  logic [47:0] res_data;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [17:0] dsp_d;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce;
  logic        dsp_rst;
  logic [47:0] dsp_p;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [17:0] job_a [8];
  logic [17:0] job_b [8];
  logic [17:0] job_d [8];

`ifdef MAC_PREADD_EN
  localparam logic [7:0] PREADD_MASK = 8'h10;
`else
  localparam logic [7:0] PREADD_MASK = 8'h00;
`endif

  dsp48a1_mac_sequencer dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
`ifdef MAC_PREADD_EN
    .in_d       (in_d),
`endif
    .res_valid  (res_valid),
    .res_data   (res_data),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_d      (dsp_d),
    .dsp_opmode (dsp_opmode),
    .dsp_ce     (dsp_ce),
    .dsp_rst    (dsp_rst),
    .dsp_p      (dsp_p)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Slice model: AREG=BREG=MREG=PREG=OPMODEREG=1, synchronous active-high reset
  logic signed [17:0] a_r, b_r;
  logic signed [35:0] m_r;
  logic        [47:0] p_r;
  logic        [7:0]  opm_r;

  always @(posedge CLK) begin
    if (dsp_rst) begin
      a_r   <= '0;
      b_r   <= '0;
      m_r   <= '0;
      p_r   <= '0;
      opm_r <= '0;
    end else if (dsp_ce) begin
      a_r <= dsp_a;
`ifdef MAC_PREADD_EN
      b_r <= opm_r[4] ? (dsp_d + dsp_b) : dsp_b;
`else
      b_r <= dsp_b;
`endif
      m_r   <= a_r * b_r;
      opm_r <= dsp_opmode;
      p_r   <= ((opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0)
             + ((opm_r[3:2] == 2'b10) ? p_r : 48'd0);
    end
  end

  assign dsp_p = p_r;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one job from job_a/job_b/job_d with `gap` idle cycles between pairs
  task automatic applyStimulus(input string name, input int n, input int gap, input logic [47:0] expected);
    int  last_cyc;
    int  waited;
    bit  got;
    last_cyc = 0;
    start = 1'b1;
    len   = 16'(n);
    tick();
    start = 1'b0;
    checkOutput({name, "_busy"}, 48'(busy), 48'd1);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_a     = job_a[i];
      in_b     = job_b[i];
`ifdef MAC_PREADD_EN
      in_d     = job_d[i];
`endif
      #1;
      waited = 0;
      while (!in_ready && waited < 20) begin
        tick();
        waited++;
      end
      checkOutput({name, "_ready"}, 48'(in_ready), 48'd1);
      checkOutput({name, "_dsp_a"}, 48'(dsp_a), 48'(job_a[i]));
      tick();
      last_cyc = cyc;
      checkOutput({name, "_opmode"}, 48'(dsp_opmode), 48'((i == 0 ? 8'h01 : 8'h09) | PREADD_MASK));
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          checkOutput({name, "_bubble_opmode"}, 48'(dsp_opmode), 48'(8'h08 | PREADD_MASK));
        end
      end
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      got = res_valid;
    end
    checkOutput({name, "_res_valid"}, 48'(got), 48'd1);
    // res_valid rises on the third edge after the last transfer
    checkOutput({name, "_latency"}, 48'(cyc - last_cyc), 48'd3);
    checkOutput({name, "_res_data"}, res_data, expected);
    tick();
    checkOutput({name, "_pulse_end"}, 48'(res_valid), 48'd0);
    checkOutput({name, "_idle"}, 48'(busy), 48'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit seen;
    RSTN     = 1'b1;
    start    = 1'b0;
    len      = '0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
`ifdef MAC_PREADD_EN
    in_d     = '0;
`endif
    for (int i = 0; i < 8; i++) begin
      job_a[i] = '0;
      job_b[i] = '0;
      job_d[i] = '0;
    end
    #1 RSTN = 1'b0;
    #2;
    checkOutput("rst_busy",      48'(busy),       48'd0);
    checkOutput("rst_in_ready",  48'(in_ready),   48'd0);
    checkOutput("rst_res_valid", 48'(res_valid),  48'd0);
    checkOutput("rst_res_data",  res_data,        48'd0);
    checkOutput("rst_dsp_a",     48'(dsp_a),      48'd0);
    checkOutput("rst_dsp_b",     48'(dsp_b),      48'd0);
    checkOutput("rst_dsp_d",     48'(dsp_d),      48'd0);
    checkOutput("rst_opmode",    48'(dsp_opmode), 48'h08);
    checkOutput("rst_dsp_ce",    48'(dsp_ce),     48'd0);
    checkOutput("rst_dsp_rst",   48'(dsp_rst),    48'd1);
    #9 RSTN = 1'b1;
    #1;
    checkOutput("release_ce",  48'(dsp_ce),  48'd1);
    checkOutput("release_rst", 48'(dsp_rst), 48'd1);
    tick();
    checkOutput("release_rst_drop", 48'(dsp_rst), 48'd0);
    tick();

    // 2*3 + 4*5 + (-1)*7 = 19
    job_a[0] = 18'd2;      job_b[0] = 18'd3;
    job_a[1] = 18'd4;      job_b[1] = 18'd5;
    job_a[2] = 18'h3FFFF;  job_b[2] = 18'd7;
    applyStimulus("dot3", 3, 0, 48'h13);
    applyStimulus("dot3_gaps", 3, 2, 48'h13);

    job_a[0] = 18'h1FFFF;  job_b[0] = 18'h1FFFF;
    applyStimulus("max_sq", 1, 0, 48'h0003FFFC0001);
    job_a[0] = 18'h20000;  job_b[0] = 18'd1;
    applyStimulus("min_x1", 1, 0, 48'hFFFFFFFE0000);

    start = 1'b1;
    len   = 16'd0;
    tick();
    start = 1'b0;
    checkOutput("len0_res_valid", 48'(res_valid), 48'd1);
    checkOutput("len0_res_data",  res_data,       48'd0);
    checkOutput("len0_in_ready",  48'(in_ready),  48'd0);
    tick();
    checkOutput("len0_pulse_end", 48'(res_valid), 48'd0);
    checkOutput("len0_idle",      48'(busy),      48'd0);

    start = 1'b1;
    len   = 16'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a     = 18'd10;
      in_b     = 18'd11;
      tick();
    end
    in_a  = 18'd9;
    in_b  = 18'd9;
    abort = 1'b1;
    #1;
    checkOutput("abort_blocks_ready", 48'(in_ready), 48'd0);
    checkOutput("abort_blocks_dsp_a", 48'(dsp_a),    48'd0);
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    checkOutput("abort_idle",     48'(busy),    48'd0);
    checkOutput("abort_dsp_rst",  48'(dsp_rst), 48'd1);
    checkOutput("abort_opmode",   48'(dsp_opmode), 48'h08);
    tick();
    checkOutput("abort_rst_drop", 48'(dsp_rst), 48'd0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      seen = seen | res_valid;
      tick();
    end
    checkOutput("abort_no_result", 48'(seen), 48'd0);

    job_a[0] = 18'd2;  job_b[0] = 18'd3;
    applyStimulus("after_abort", 1, 0, 48'd6);

`ifdef MAC_PREADD_EN
    job_a[0] = 18'd2;  job_b[0] = 18'd3;  job_d[0] = 18'd5;
    applyStimulus("preadd", 1, 0, 48'd16);
    job_d[0] = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
